// File: rtl/rotl_engine_if.sv
// Request/result handshake bundle for the sequential left-rotate engine.
// The master drives requests and consumes results; the slave is the engine.
interface rotl_engine_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/rotl_engine.sv
// Sequential left rotator: accepts a byte plus amount, rotates left by at most
// STEP_MAX positions per clock, then holds the result until it is taken.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// ROTATE | applying up to STEP_MAX positions per cycle, rem_q counts down
// DONE   | result valid, held until out_ready
module rotl_engine #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 3,
    parameter int STEP_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    rotl_engine_if.slave   rot_io
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] STEP_L = AMT_W'(STEP_MAX);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] rem_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    logic [AMT_W-1:0] step;
    logic [AMT_W-1:0] rem_d;
    logic [WIDTH-1:0] data_d;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                              input logic [AMT_W-1:0] s);
        logic [2*WIDTH-1:0] t;
        t = {d, d} << s;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    always_comb begin
        step   = (rem_q > STEP_L) ? STEP_L : rem_q;
        rem_d  = rem_q - step;
        data_d = rotl(data_q, step);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rot_io.in_valid) begin
                        data_q <= rot_io.in_data;
                        rem_q  <= rot_io.in_amt;
                        // zero amount skips ROTATE and presents the input directly
                        if (rot_io.in_amt == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= rot_io.in_data;
                        end else begin
                            state_q <= ROTATE;
                        end
                    end
                end
                ROTATE: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_d;
                    end
                end
                DONE: begin
                    if (rot_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rot_io.in_ready  = (state_q == IDLE) && !rst;
    assign rot_io.busy      = (state_q != IDLE);
    assign rot_io.out_valid = out_valid_q;
    assign rot_io.out_data  = out_data_q;

endmodule

// File: tb/tb_rotl_engine.sv
// Directed bench for rotl_engine: hand-computed vectors, backpressure,
// mid-operation reset and a right-rotate/left-rotate inverse sweep.
module tb_rotl_engine;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    rotl_engine_if #(.WIDTH(8), .AMT_W(3)) bus ();

    rotl_engine #(.WIDTH(8), .AMT_W(3), .STEP_MAX(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .rot_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] d, input logic [2:0] a);
        int waited;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Called 1 time unit after the accept edge.
    task automatic collect(input string tag, input logic [7:0] exp_d, input int exp_lat);
        int lat;
        lat = 1;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_in_ready_lo"}, 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
            chk({tag, "_in_ready_lo"}, 32'(bus.in_ready), 32'd0);
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] dd;
        logic [7:0]  rin;
        n_chk  = 0;
        n_fail = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("first_in_ready", 32'(bus.in_ready), 32'd1);

        issue(8'h96, 3'd0);
        collect("amt0", 8'h96, 1);
        handshake("amt0");

        issue(8'h81, 3'd1);
        collect("amt1", 8'h03, 2);
        handshake("amt1");

        issue(8'h12, 3'd4);
        collect("amt4", 8'h21, 3);
        handshake("amt4");

        issue(8'hB4, 3'd7);
        collect("amt7", 8'h5A, 4);
        handshake("amt7");

        // Backpressure with a pending request held on the input side.
        issue(8'hC3, 3'd2);
        collect("bp", 8'h0F, 2);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h12;
        bus.in_amt   = 3'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data", 32'(bus.out_data), 32'h0F);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_hs_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        collect("bp_pending", 8'h21, 3);
        handshake("bp_pending");

        // Reset during the second ROTATE cycle.
        issue(8'hFF, 3'd7);
        @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        issue(8'h01, 3'd5);
        collect("post_rst", 8'h20, 3);
        handshake("post_rst");

        // Right-rotate by s then left-rotate by s must restore the byte.
        for (int d = 0; d < 256; d++) begin
            for (int s = 0; s < 4; s++) begin
                dd  = {8'(d), 8'(d)} >> s;
                rin = dd[7:0];
                issue(rin, 3'(s));
                collect("sweep", 8'(d), (s == 0) ? 1 : 2);
                handshake("sweep");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
